mem_access_ctrl: RTL and testbench

Sequencer for the MEM stage's data-memory port in the pipelined MIPS core. It accepts one load or store per pipeline request and drives a multi-cycle, ack-based data memory with word address, byte enables and lane-replicated write data. It stalls the pipeline until the access completes, returns sign- or zero-extended load results, and flags bus timeouts and, optionally, misaligned addresses.

---
 rtl/mem_access_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: one load/store per request, ack-based bus, timeout detection.
// Optional misaligned-address rejection is compiled in with `define ALIGN_CHECK_EN.
//   state | meaning
//   IDLE  | waiting for a legal request; latches the access on accept
//   REQ   | mem_req held, waiting for mem_ack or timeout
//   DONE  | one-cycle completion: load_valid or bus_err pulse
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        addr_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [7:0] TC     = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic [5:0]  op_q;
  logic [1:0]  lo_q;
  logic        err_q;
  logic        legal, misalign, req_take, accept, timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  always_comb begin
    legal = is_load(req_op) || is_store(req_op);
`ifdef ALIGN_CHECK_EN
    misalign = (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0]) ||
               (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    // Gating with rst_n keeps stall/addr_err low while reset is held.
    req_take    = rst_n && (state == IDLE) && req_valid && legal;
    accept      = req_take && !misalign;
    cnt_inc     = cnt + 8'd1;
    timeout_hit = (cnt_inc == TC);
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = req_wdata;
    case (req_op)
      OP_SB: begin
        be_nxt    = 4'b0001 << req_addr[1:0];
        wdata_nxt = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[{lo_q, 3'b000} +: 8];
    half_sel = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'h0, byte_sel};
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'h0, half_sel};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (mem_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall      = accept || (state == REQ);
    addr_err   = req_take && misalign;
    mem_req    = (state == REQ);
    load_valid = (state == DONE) && !err_q && is_load(op_q);
    bus_err    = (state == DONE) && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 8'd0;
      op_q      <= 6'd0;
      lo_q      <= 2'd0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      load_data <= 32'd0;
    end else begin
      if (accept) begin
        cnt       <= 8'd0;
        op_q      <= req_op;
        lo_q      <= req_addr[1:0];
        err_q     <= 1'b0;
        mem_we    <= is_store(req_op);
        mem_be    <= be_nxt;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= wdata_nxt;
      end
      if (state == REQ) begin
        // An ack in the final counted cycle still completes normally.
        if (mem_ack) begin
          if (is_load(op_q)) load_data <= ext_data;
        end else begin
          cnt <= cnt_inc;
          if (timeout_hit) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed test-plan cases plus random accesses
// checked cycle by cycle against a spec-level reference model.
module tb_mem_access_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [5:0]  req_op = 6'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall, load_valid, bus_err, addr_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] load_data, mem_addr, mem_wdata;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_ld = 32'h0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .load_valid(load_valid), .load_data(load_data), .bus_err(bus_err),
    .addr_err(addr_err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_ld(input logic [5:0] op);
    return op inside {6'h20, 6'h24, 6'h21, 6'h25, 6'h23};
  endfunction

  function automatic bit m_legal(input logic [5:0] op);
    return m_is_ld(op) || (op inside {6'h28, 6'h29, 6'h2B});
  endfunction

  function automatic bit m_mis(input logic [5:0] op, input logic [31:0] addr);
`ifdef ALIGN_CHECK_EN
    return ((op inside {6'h21, 6'h25, 6'h29}) && (addr % 2 != 0)) ||
           ((op inside {6'h23, 6'h2B}) && (addr % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (op == 6'h28) return 4'(1 << a);
    if (op == 6'h29) return (a >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [5:0] op, input logic [31:0] wd);
    if (op == 6'h28) return (wd & 32'hFF) * 32'h0101_0101;
    if (op == 6'h29) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [5:0] op, input logic [31:0] addr,
                                       input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (addr % 4))) & 32'hFF;
    h = (rd >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
    case (op)
      6'h20:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      6'h24:   return b;
      6'h21:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      6'h25:   return h;
      default: return rd;
    endcase
  endfunction

  // k = cycle (after the request cycle) on which mem_ack is driven; 0 = never.
  task automatic do_access(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int k, input logic [31:0] rd);
    bit ok;
    int last;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; mem_ack = 1'b0;
    @(negedge clk);
    if (!m_legal(op) || m_mis(op, addr)) begin
      chk("rej_stall", {31'b0, stall}, 32'd0);
      chk("rej_addr_err", {31'b0, addr_err}, {31'b0, m_legal(op) && m_mis(op, addr)});
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rej_mem_req", {31'b0, mem_req}, 32'd0);
      return;
    end
    chk("c0_stall", {31'b0, stall}, 32'd1);
    chk("c0_mem_req", {31'b0, mem_req}, 32'd0);
    chk("c0_addr_err", {31'b0, addr_err}, 32'd0);
    ok = (k >= 1) && (k <= TO);
    last = ok ? k : TO;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      mem_ack = (c == k);
      mem_rdata = (c == k) ? rd : $urandom;
      @(negedge clk);
      chk("req_mem_req", {31'b0, mem_req}, 32'd1);
      chk("req_stall", {31'b0, stall}, 32'd1);
      chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("req_be", {28'b0, mem_be}, {28'b0, m_be(op, addr)});
      chk("req_we", {31'b0, mem_we}, {31'b0, !m_is_ld(op)});
      if (!m_is_ld(op)) chk("req_wdata", mem_wdata, m_wd(op, wd));
      chk("req_load_valid", {31'b0, load_valid}, 32'd0);
      chk("req_bus_err", {31'b0, bus_err}, 32'd0);
    end
    @(posedge clk); #1;
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    if (ok && m_is_ld(op)) exp_ld = m_ld(op, addr, rd);
    chk("done_load_valid", {31'b0, load_valid}, {31'b0, ok && m_is_ld(op)});
    chk("done_bus_err", {31'b0, bus_err}, {31'b0, !ok});
    chk("done_stall", {31'b0, stall}, 32'd0);
    chk("done_mem_req", {31'b0, mem_req}, 32'd0);
    chk("done_load_data", load_data, exp_ld);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_ack = 1'($urandom);
    @(negedge clk);
    chk("idle_stall", {31'b0, stall}, 32'd0);
    chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
    chk("idle_load_valid", {31'b0, load_valid}, 32'd0);
    chk("idle_bus_err", {31'b0, bus_err}, 32'd0);
    chk("idle_load_data", load_data, exp_ld);
    mem_ack = 1'b0;
  endtask

  logic [5:0] ops [9] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h3F};

  initial begin
    req_valid = 1'b1; req_op = 6'h23; req_addr = 32'h100;
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_flags", {29'b0, load_valid, bus_err, addr_err}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_access(6'h20, 32'h0000_1003, 32'h0, 3, 32'h80FF_1234);
    chk("tp_lb_data", load_data, 32'hFFFF_FF80);
    do_access(6'h25, 32'h0000_2002, 32'h0, 1, 32'h8001_0000);
    chk("tp_lhu_data", load_data, 32'h0000_8001);
    do_access(6'h28, 32'h0000_3001, 32'h0000_00AB, 2, 32'h0);
    do_access(6'h29, 32'h0000_3002, 32'h1234_5678, 1, 32'h0);
    do_access(6'h23, 32'h0000_5000, 32'h0, 0, 32'h0);
    chk("tp_timeout_keep", load_data, 32'h0000_8001);
    do_access(6'h23, 32'h0000_5004, 32'h0, TO, 32'hCAFE_F00D);
    do_access(6'h23, 32'h0000_4002, 32'h0, 2, 32'h1357_9BDF);
    do_access(6'h3F, 32'h0000_6000, 32'h0, 1, 32'h0);

    for (int i = 0; i < 60; i++) begin
      int k;
      k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      do_access(ops[$urandom_range(0, 8)], $urandom, $urandom, k, $urandom);
    end

    do_access(6'h20, 32'h0000_7001, 32'h0, 1, 32'h0000_5500);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 6'h23; req_addr = 32'h0000_8000; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    exp_ld = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 1'b0;
    do_access(6'h23, 32'h0000_8008, 32'h0, 2, 32'hA5A5_0F0F);
    chk("post_rst_lw", load_data, 32'hA5A5_0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
